word_stream_descramble_sync: RTL and testbench

Receive-side counterpart of the word-stream scrambler. It takes a self-synchronising scrambled word stream and descrambles it with polynomial x^7+x^6+1. It then acquires frame alignment on a periodic SYNC_WORD and delivers only payload words, with start-of-frame marking, once lock is established. It sits between the link/deserialiser word interface and payload consumers.

---
 rtl/word_stream_descramble_sync_pkg.sv | 16 +
 rtl/word_stream_descramble_sync_if.sv | 23 ++
 rtl/word_stream_descramble_sync_core.sv | 47 ++++
 rtl/word_stream_descramble_sync.sv | 165 ++++++++++++++++
 tb/tb_word_stream_descramble_sync.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/word_stream_descramble_sync_pkg.sv
// Shared types and constants for the word-stream descrambler / frame sync block.
package word_stream_pkg;

  // Frame alignment states
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // x^7 + x^6 + 1 self-synchronising scrambler taps
  localparam int unsigned SCR_TAP_A    = 6;
  localparam int unsigned SCR_TAP_B    = 7;
  localparam int unsigned SCR_HIST_LEN = 7;

endpackage

// File: rtl/word_stream_descramble_sync_if.sv
// Word interface between the deserialiser (master) and the descramble/sync block (slave).
// Optional WORD_STREAM_SYNC_STATS_EN adds the sync error counter.
interface word_stream_descramble_sync_if #(
  parameter int unsigned WORD_LEN = 8
) ();

  logic                ena;
  logic [WORD_LEN-1:0] din;
  logic [WORD_LEN-1:0] dout;
  logic                dout_valid;
  logic                sof;
  logic                locked;
`ifdef WORD_STREAM_SYNC_STATS_EN
  logic [15:0]         sync_err_cnt;

  modport master (output ena, din, input dout, dout_valid, sof, locked, sync_err_cnt);
  modport slave  (input ena, din, output dout, dout_valid, sof, locked, sync_err_cnt);
`else
  modport master (output ena, din, input dout, dout_valid, sof, locked);
  modport slave  (input ena, din, output dout, dout_valid, sof, locked);
`endif

endinterface

// File: rtl/word_stream_descramble_sync_core.sv
// Stage 1: x^7+x^6+1 descrambler, LSB first, history carried across words.
module word_stream_descramble_core
  import word_stream_pkg::*;
#(
  parameter int unsigned WORD_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena_i,
  input  logic [WORD_LEN-1:0] din_i,
  output logic [WORD_LEN-1:0] s1_data_o,
  output logic                s1_valid_o
);

  logic [SCR_HIST_LEN-1:0] hist_q, hist_d;
  logic [WORD_LEN-1:0]     s1_data_q, s1_data_d;
  logic                    s1_valid_q;
  logic [SCR_HIST_LEN-1:0] hist;

  // Bit-serial descramble of one word; hist[k-1] holds the bit received k bits ago
  always_comb begin
    hist      = hist_q;
    s1_data_d = '0;
    for (int i = 0; i < int'(WORD_LEN); i++) begin
      s1_data_d[i] = din_i[i] ^ hist[SCR_TAP_A-1] ^ hist[SCR_TAP_B-1];
      hist         = {hist[SCR_HIST_LEN-2:0], din_i[i]};
    end
    hist_d = hist;
  end

  // Stage-1 register; s1_valid marks that a word is waiting for the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q     <= '0;
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else if (ena_i) begin
      hist_q     <= hist_d;
      s1_data_q  <= s1_data_d;
      s1_valid_q <= 1'b1;
    end
  end

  assign s1_data_o  = s1_data_q;
  assign s1_valid_o = s1_valid_q;

endmodule

// File: rtl/word_stream_descramble_sync.sv
// Descrambles a word stream, acquires frame lock on SYNC_WORD and emits payload words.
// The whole pipeline advances only on ena, so stalls never drop or reorder words.
// Optional macro WORD_STREAM_SYNC_STATS_EN adds a saturating locked sync-miss counter.
module word_stream_descramble_sync
  import word_stream_pkg::*;
#(
  parameter int unsigned         WORD_LEN  = 8,
  parameter int unsigned         FRAME_LEN = 16,
  parameter logic [WORD_LEN-1:0] SYNC_WORD = WORD_LEN'(8'hA5),
  parameter int unsigned         LOCK_CNT  = 3,
  parameter int unsigned         MISS_CNT  = 4
) (
  input logic clk,
  input logic rst,
  word_stream_descramble_sync_if.slave bus
);

  localparam int unsigned POS_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned HIT_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = $clog2(MISS_CNT + 1);

  logic [WORD_LEN-1:0] s1_data;
  logic                s1_valid;

  state_e              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d, pos_next;
  logic [HIT_W-1:0]    hits_q, hits_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [WORD_LEN-1:0] dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                sof_q, sof_d;
  logic                locked_q, locked_d;
  logic                eval_c, is_sync_c;
`ifdef WORD_STREAM_SYNC_STATS_EN
  logic [15:0]         err_q, err_d;
`endif

  word_stream_descramble_core #(
    .WORD_LEN (WORD_LEN)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .ena_i      (bus.ena),
    .din_i      (bus.din),
    .s1_data_o  (s1_data),
    .s1_valid_o (s1_valid)
  );

  // Frame sync FSM and payload output selection
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    hits_d       = hits_q;
    miss_d       = miss_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sof_d        = 1'b0;
`ifdef WORD_STREAM_SYNC_STATS_EN
    err_d        = err_q;
`endif
    eval_c    = bus.ena && s1_valid;
    is_sync_c = (s1_data == SYNC_WORD);
    pos_next  = (pos_q == POS_W'(FRAME_LEN - 1)) ? '0 : pos_q + POS_W'(1);

    if (eval_c) begin
      unique case (state_q)
        HUNT: begin
          if (is_sync_c) begin
            pos_d   = POS_W'(1);
            hits_d  = HIT_W'(1);
            miss_d  = '0;
            state_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
          end
        end
        VERIFY: begin
          pos_d = pos_next;
          if (pos_q == '0) begin
            if (is_sync_c) begin
              hits_d = hits_q + HIT_W'(1);
              if ((hits_q + HIT_W'(1)) == HIT_W'(LOCK_CNT)) begin
                state_d = LOCKED;
                miss_d  = '0;
              end
            end else begin
              // Abandon this alignment; the failing word is not a new candidate
              state_d = HUNT;
              pos_d   = '0;
              hits_d  = '0;
            end
          end
        end
        LOCKED: begin
          pos_d = pos_next;
          if (pos_q == '0) begin
            if (is_sync_c) begin
              miss_d = '0;
            end else begin
`ifdef WORD_STREAM_SYNC_STATS_EN
              if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
`endif
              if ((miss_q + MISS_W'(1)) == MISS_W'(MISS_CNT)) begin
                state_d = HUNT;
                pos_d   = '0;
                hits_d  = '0;
                miss_d  = '0;
              end else begin
                miss_d = miss_q + MISS_W'(1);
              end
            end
          end else begin
            dout_d       = s1_data;
            dout_valid_d = 1'b1;
            sof_d        = (pos_q == POS_W'(1));
          end
        end
        default: begin
          state_d = HUNT;
          pos_d   = '0;
          hits_d  = '0;
          miss_d  = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // Stage-2 state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      pos_q        <= '0;
      hits_q       <= '0;
      miss_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      locked_q     <= 1'b0;
`ifdef WORD_STREAM_SYNC_STATS_EN
      err_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      hits_q       <= hits_d;
      miss_q       <= miss_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sof_q        <= sof_d;
      locked_q     <= locked_d;
`ifdef WORD_STREAM_SYNC_STATS_EN
      err_q        <= err_d;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.sof        = sof_q;
  assign bus.locked     = locked_q;
`ifdef WORD_STREAM_SYNC_STATS_EN
  assign bus.sync_err_cnt = err_q;
`endif

endmodule

// File: tb/tb_word_stream_descramble_sync.sv
// Directed bench for word_stream_descramble_sync: behavioural x^7+x^6+1 scrambler feeds
// framed words; expectations come from frame position bookkeeping.
module tb_word_stream_descramble_sync;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  word_stream_descramble_sync_if #(.WORD_LEN(8)) bus ();

  word_stream_descramble_sync #(
    .WORD_LEN  (8),
    .FRAME_LEN (16),
    .SYNC_WORD (8'hA5),
    .LOCK_CNT  (3),
    .MISS_CNT  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       ena;
    logic [7:0] plain;
    logic       el;
    logic       ev;
    logic [7:0] ed;
    logic       es;
  } vec_t;

  vec_t       vecs [80];
  int         checks = 0;
  int         errors = 0;
  int         stepno = 0;
  logic [6:0] scr_hist = 7'd0;

  // Behavioural scrambler: s[i] = d[i] ^ s[i-6] ^ s[i-7], LSB first
  task automatic scramble(input logic [7:0] d, output logic [7:0] s);
    logic b;
    s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b        = d[i] ^ scr_hist[5] ^ scr_hist[6];
      s[i]     = b;
      scr_hist = {scr_hist[5:0], b};
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d actual %0h expected %0h", name, stepno, act, exp);
    end
  endtask

  // Drive one word at the negedge, let one posedge pass, return at the next negedge
  task automatic step(input logic e, input logic [7:0] plain);
    logic [7:0] sw;
    if (e) scramble(plain, sw);
    else   sw = 8'h3C;
    bus.ena = e;
    bus.din = sw;
    @(posedge clk);
    @(negedge clk);
    stepno++;
  endtask

  task automatic exp_out(input string tag, input logic el, input logic ev,
                         input logic [7:0] ed, input logic es);
    chk({tag, "_locked"}, 32'(bus.locked), 32'(el));
    chk({tag, "_valid"}, 32'(bus.dout_valid), 32'(ev));
    if (ev) begin
      chk({tag, "_dout"}, 32'(bus.dout), 32'(ed));
      chk({tag, "_sof"}, 32'(bus.sof), 32'(es));
    end
  endtask

  // Frame words first_p..last_p while lock is held; output lags input by one word
  task automatic locked_frame(input string tag, input logic [7:0] sync_plain,
                              input int first_p, input int last_p);
    for (int p = first_p; p <= last_p; p++) begin
      step(1'b1, (p == 0) ? sync_plain : 8'(p));
      exp_out(tag, 1'b1, p != 1, 8'((p + 15) % 16), p == 2);
    end
  endtask

  // n frames from HUNT/VERIFY; lock is reached by the sync of the last frame
  task automatic acquire(input string tag, input int first_p, input int n);
    for (int f = 0; f < n; f++) begin
      for (int p = (f == 0) ? first_p : 0; p < 16; p++) begin
        step(1'b1, (p == 0) ? 8'hA5 : 8'(p));
        exp_out(tag, (f == n - 1) && (p >= 1), (f == n - 1) && (p >= 2),
                8'(p - 1), p == 2);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog step %0d actual running expected finished", stepno);
    $fatal(1, "timeout");
  end

  initial begin
    int         sent;
    int         rcv;
    int         iter;
    logic       e;
    logic [7:0] nextp;
    logic [7:0] last_exp;

    rst     = 1'b1;
    bus.ena = 1'b0;
    bus.din = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_sof", 32'(bus.sof), 32'd0);
    chk("rst_locked", 32'(bus.locked), 32'd0);
`ifdef WORD_STREAM_SYNC_STATS_EN
    chk("rst_errcnt", 32'(bus.sync_err_cnt), 32'd0);
`endif
    rst = 1'b0;

    // Clean acquisition: lock on the 3rd sync, payload from the next pos-1 word
    for (int k = 0; k < 80; k++) begin
      vecs[k].ena   = 1'b1;
      vecs[k].plain = (k % 16 == 0) ? 8'hA5 : 8'(k % 16);
      vecs[k].el    = (k >= 33);
      vecs[k].ev    = (k >= 34) && ((k - 1) % 16 != 0);
      vecs[k].ed    = 8'((k - 1) % 16);
      vecs[k].es    = ((k - 1) % 16 == 1);
    end
    for (int k = 0; k < 80; k++) begin
      step(vecs[k].ena, vecs[k].plain);
      exp_out("acq", vecs[k].el, vecs[k].ev, vecs[k].ed, vecs[k].es);
    end

    // Lock loss: three misses hold lock, a good sync clears, four misses drop it
    for (int i = 0; i < 3; i++) locked_frame("miss3", 8'h00, 0, 15);
    locked_frame("good", 8'hA5, 0, 15);
    for (int i = 0; i < 3; i++) locked_frame("miss", 8'h00, 0, 15);
    // 4th miss; a fake A5 payload at pos 7 then steers HUNT to a false alignment
    for (int p = 0; p < 16; p++) begin
      step(1'b1, (p == 0) ? 8'h00 : (p == 7) ? 8'hA5 : 8'(p));
      if (p == 0) exp_out("drop", 1'b1, 1'b1, 8'h0F, 1'b0);
      else        exp_out("drop", 1'b0, 1'b0, 8'h00, 1'b0);
    end
    // False sync costs the next true sync; lock needs three further true syncs
    acquire("false", 0, 4);

    // Random stalls while locked: gapless, in order, no valid after an ena=0 edge
    sent     = 0;
    rcv      = 0;
    nextp    = 8'd15;
    last_exp = 8'h0E;
    iter     = 0;
    while (sent < 48 && iter < 1000) begin
      e = 1'($urandom_range(0, 1));
      step(e, (sent % 16 == 0) ? 8'hA5 : 8'(sent % 16));
      iter++;
      chk("stall_locked", 32'(bus.locked), 32'd1);
      if (!e) begin
        chk("stall_valid", 32'(bus.dout_valid), 32'd0);
        chk("stall_hold", 32'(bus.dout), 32'(last_exp));
      end else begin
        sent++;
        if (bus.dout_valid) begin
          chk("stall_dout", 32'(bus.dout), 32'(nextp));
          chk("stall_sof", 32'(bus.sof), 32'(nextp == 8'd1));
          last_exp = nextp;
          nextp    = (nextp == 8'd15) ? 8'd1 : nextp + 8'd1;
          rcv++;
        end
      end
    end
    chk("stall_sent", 32'(sent), 32'd48);
    chk("stall_count", 32'(rcv), 32'd45);
    locked_frame("post_stall", 8'hA5, 0, 15);

    // Reset at pos 9 while locked, then full re-acquisition
    locked_frame("pre_rst", 8'hA5, 0, 9);
`ifdef WORD_STREAM_SYNC_STATS_EN
    chk("errcnt_7", 32'(bus.sync_err_cnt), 32'd7);
`endif
    rst     = 1'b1;
    bus.ena = 1'b1;
    bus.din = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    stepno++;
    chk("mid_rst_dout", 32'(bus.dout), 32'd0);
    chk("mid_rst_valid", 32'(bus.dout_valid), 32'd0);
    chk("mid_rst_sof", 32'(bus.sof), 32'd0);
    chk("mid_rst_locked", 32'(bus.locked), 32'd0);
`ifdef WORD_STREAM_SYNC_STATS_EN
    chk("mid_rst_errcnt", 32'(bus.sync_err_cnt), 32'd0);
`endif
    rst      = 1'b0;
    scr_hist = 7'd0;
    acquire("reacq", 10, 4);

`ifdef WORD_STREAM_SYNC_STATS_EN
    // Five isolated sync misses while locked
    for (int i = 0; i < 5; i++) begin
      locked_frame("stat_bad", 8'h00, 0, 15);
      if (i < 4) locked_frame("stat_good", 8'hA5, 0, 15);
    end
    chk("errcnt_5", 32'(bus.sync_err_cnt), 32'd5);
    chk("stat_locked", 32'(bus.locked), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
